fsk_tx: RTL and testbench
=========================

# fsk_tx

Byte-oriented binary FSK transmitter for the modulation side of the chapter-8 modem chain. It accepts bytes over a valid/ready handshake and frames each one UART-style: a start bit, NBITS data bits LSB first, then a stop bit. Each bit is mapped to a mark or space frequency word, and that word drives a continuous-phase DDS. The output is a Q1.DW-1 sample stream at clock rate, suitable for the IF channel and band-pass/discriminator chain already used for WBFM.

## Interface
- DW, 12, output sample width (Q1.DW-1)
- PW, 24, phase/frequency word width
- NBITS, 8, data bits per frame
- BAUD_DIV, 1000, clock-enable cycles per bit; must be ≥ 2
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  clock enable; low freezes all state including the DDS
- mark_freq  in  PW signed  frequency word for bit 1 (freq/fs·2^PW)
- space_freq  in  PW signed  frequency word for bit 0
- s_data  in  NBITS  byte to send
- s_valid  in  1  s_data valid
- s_ready  out  1  block can accept a byte
- busy  out  1  frame in progress
- tx_bit  out  1  current line bit (1 = mark)
- modout  out  DW signed  FSK sample, Q1.DW-1

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - s_ready = en.
  - tx_bit = 1; freq word follows the live mark_freq.
  - The transfer s_valid && s_ready && en latches s_data into a shift register and latches mark_freq/space_freq into frame registers. The next state is START.
- START: tx_bit = 0 for one bit period.
- DATA: tx_bit = shreg[0]. At each bit boundary, shift right and increment the bit counter (0..NBITS-1). After bit NBITS-1, go to STOP.
- STOP: tx_bit = 1 for one bit period, then go to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 on en cycles.
  - Its terminal count is the bit boundary.
  - It clears on accept and on rst.
- Frequency word: registered as tx_bit ? mark : space, using the frame registers outside IDLE. It is updated in the same cycle as tx_bit.
- Phase continuity: the DDS phase accumulator is never reset except by rst. Frequency changes are therefore phase-continuous.
- busy = (state != IDLE). s_ready is never high while busy.
- Mid-frame input changes: changes to s_data, mark_freq or space_freq during a frame have no effect on that frame.
- Reset mid-frame: the frame is aborted. State goes to IDLE, the shift register and counters clear, and there is no resumption.
- en low: all registers hold, including the DDS. Bit periods stretch by the number of en-low cycles.

## Timing
- Reset values: s_ready = 0 while rst is high, busy = 0, tx_bit = 1, freq word = 0, modout = 0.
- First cycle after rst: s_ready = en; freq word = mark_freq.
- Accept at posedge T. Relative to T (en held high):
  - tx_bit = 0 on cycles T+1 .. T+BAUD_DIV.
  - Data bit i occupies T+1+(i+1)·BAUD_DIV, for BAUD_DIV cycles.
  - Stop bit starts at T+1+(NBITS+1)·BAUD_DIV.
  - s_ready rises at T+1+(NBITS+2)·BAUD_DIV.
- Frame length: (NBITS+2)·BAUD_DIV cycles.
- Minimum gap between frames: 1 cycle of IDLE mark.
- modout lags tx_bit/freq word by the DDS pipeline latency L_DDS, which is fixed and documented by the DDS module.

## Structure
- Package fsk_pkg holds:
  - the state enum typedef {IDLE, START, DATA, STOP};
  - the function bit_start_cycle(i, BAUD_DIV), shared with the bench.
- Sub-module: the existing DDS #(PW, DW, DW+2), instantiated once.
  - Frequency input: the registered freq word.
  - Phase input: 0.
  - en: passed through.
- Framing FSM, baud counter and shift register are in fsk_tx (~150 lines).

## Test plan
- Reset: hold rst 10 cycles → s_ready = 0, busy = 0, tx_bit = 1, modout = 0 throughout. The cycle after release, s_ready = 1 and the freq word is 3355443 (20 MHz at 100 Msps).
- Single byte: BAUD_DIV = 16, send 0xA5 → tx_bit is 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. busy is high for 160 cycles. s_ready returns at T+161.
- Back-to-back: s_valid held with 0x00 then 0xFF → the second accept happens on the first cycle s_ready returns. There is exactly 1 mark cycle between the first stop bit and the second start bit.
- Enable gating: en toggled 1/0 every cycle during a 0x3C frame → the bit pattern is identical to the en = 1 case. Every bit lasts 32 clocks.
- Reset mid-frame: assert rst during data bit 3 → the next cycle has busy = 0 and tx_bit = 1. A following 0x81 frame is sent complete and correct.
- Continuity/frequency: mark = 3355443 (20 MHz), space = 2516582 (15 MHz), BAUD_DIV = 1000 → zero-crossing count per bit is 400±2 for mark and 300±2 for space. At every bit boundary, |modout[n]−modout[n−1]| ≤ 2π·0.2·2^(DW−1)+2 LSB.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared types and helpers for the FSK transmitter and anything that needs to
// reason about its frame timing.
package fsk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } fsk_state_e;

    // Cycles from freq word change to the first affected modout sample.
    localparam int DDS_LATENCY = 3;

    // First cycle of data bit i, counted from the accepting clock edge (edge = 0).
    function automatic int bit_start_cycle(input int i, input int baud_div);
        return 1 + (i + 1) * baud_div;
    endfunction

endpackage

// File: rtl/fsk_if.sv
// Byte stream handshake into the FSK transmitter.
interface fsk_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fsk_tx_dds.sv
// Continuous-phase DDS: PW-bit phase accumulator truncated to TW bits, quarter-wave
// odd polynomial sine. freq_i to sample_o latency is 3 enabled cycles.
module fsk_tx_dds #(
    parameter int PW = 24,
    parameter int DW = 12,
    parameter int TW = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic signed [PW-1:0] freq_i,
    input  logic [PW-1:0]        phase_i,
    output logic signed [DW-1:0] sample_o
);
    localparam int FW = TW - 2;
    localparam logic [FW:0] QUARTER = {1'b1, {FW{1'b0}}};
    // sin(pi/2*u) ~= u*(A - B*u^2 + C*u^4), coefficients scaled by 2^14
    localparam logic [47:0] C_A = 48'd25736;
    localparam logic [47:0] C_B = 48'd10583;
    localparam logic [47:0] C_C = 48'd1229;
    localparam logic [47:0] AMP = (48'd1 << (DW - 1)) - 48'd1;

    logic [PW-1:0]        acc_q;
    logic [PW-1:0]        phase_w;
    logic [TW-1:0]        trunc_w;
    logic [FW:0]          u_q;
    logic [FW:0]          u_d;
    logic                 neg_q;
    logic [47:0]          u_w;
    logic [47:0]          u2_w;
    logic [47:0]          u4_w;
    logic [47:0]          poly_w;
    logic signed [DW-1:0] mag_s;
    logic signed [DW-1:0] sample_d;
    logic signed [DW-1:0] sample_q;

    always_comb begin
        phase_w = acc_q + phase_i;
        trunc_w = TW'(phase_w >> (PW - TW));
        // Odd quadrants run backwards through the quarter wave.
        u_d = trunc_w[TW-2] ? QUARTER - {1'b0, trunc_w[FW-1:0]} : {1'b0, trunc_w[FW-1:0]};
    end

    always_comb begin
        u_w      = 48'(u_q);
        u2_w     = (u_w * u_w) >> FW;
        u4_w     = (u2_w * u2_w) >> FW;
        poly_w   = C_A - ((C_B * u2_w) >> FW) + ((C_C * u4_w) >> FW);
        mag_s    = $signed(DW'(((((u_w * poly_w) >> FW) * AMP) >> 14)));
        sample_d = neg_q ? -mag_s : mag_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            u_q      <= '0;
            neg_q    <= 1'b0;
            sample_q <= '0;
        end else if (en_i) begin
            acc_q    <= acc_q + $unsigned(freq_i);
            u_q      <= u_d;
            neg_q    <= trunc_w[TW-1];
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/fsk_tx.sv
// Byte-framed binary FSK transmitter: start bit, NBITS data bits LSB first, stop bit,
// each bit steering a continuous-phase DDS between mark and space frequency words.
//   state | meaning
//   IDLE  | line at mark, live mark word, ready for a byte while enabled
//   START | space for one bit period
//   DATA  | shreg[0] on the line, NBITS bit periods
//   STOP  | mark for one bit period
module fsk_tx
    import fsk_pkg::*;
#(
    parameter int DW       = 12,
    parameter int PW       = 24,
    parameter int NBITS    = 8,
    parameter int BAUD_DIV = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic signed [PW-1:0] mark_freq_i,
    input  logic signed [PW-1:0] space_freq_i,
    fsk_if.slave                 s_if,
    output logic                 busy_o,
    output logic                 tx_bit_o,
    output logic signed [PW-1:0] freq_word_o,
    output logic signed [DW-1:0] modout_o
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BC_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(NBITS - 1);

    fsk_state_e           state_q;
    logic [CNT_W-1:0]     baud_q;
    logic [BC_W-1:0]      bit_q;
    logic [NBITS-1:0]     shreg_q;
    logic signed [PW-1:0] mark_q;
    logic signed [PW-1:0] space_q;
    logic signed [PW-1:0] freq_q;
    logic                 tx_bit_q;
    logic                 accept;
    logic                 bit_tick;

    assign s_if.s_ready = (state_q == IDLE) && en_i && !rst;
    assign accept       = s_if.s_valid && s_if.s_ready;
    assign bit_tick     = en_i && (state_q != IDLE) && (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            mark_q   <= '0;
            space_q  <= '0;
            freq_q   <= '0;
            tx_bit_q <= 1'b1;
        end else if (en_i) begin
            if (state_q != IDLE) begin
                baud_q <= bit_tick ? '0 : baud_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // Frame words come from the live inputs on this edge, then stay frozen.
                        state_q  <= START;
                        baud_q   <= '0;
                        bit_q    <= '0;
                        shreg_q  <= s_if.s_data;
                        mark_q   <= mark_freq_i;
                        space_q  <= space_freq_i;
                        tx_bit_q <= 1'b0;
                        freq_q   <= space_freq_i;
                    end else begin
                        tx_bit_q <= 1'b1;
                        freq_q   <= mark_freq_i;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state_q  <= DATA;
                        tx_bit_q <= shreg_q[0];
                        freq_q   <= shreg_q[0] ? mark_q : space_q;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_q == BIT_LAST) begin
                            state_q  <= STOP;
                            tx_bit_q <= 1'b1;
                            freq_q   <= mark_q;
                        end else begin
                            bit_q    <= bit_q + 1'b1;
                            shreg_q  <= shreg_q >> 1;
                            tx_bit_q <= shreg_q[1];
                            freq_q   <= shreg_q[1] ? mark_q : space_q;
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        state_q  <= IDLE;
                        tx_bit_q <= 1'b1;
                        freq_q   <= mark_freq_i;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign tx_bit_o    = tx_bit_q;
    assign freq_word_o = freq_q;

    // Phase is never cleared between frames, so bit transitions stay phase-continuous.
    fsk_tx_dds #(
        .PW (PW),
        .DW (DW),
        .TW (DW + 2)
    ) u_dds (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .freq_i   (freq_q),
        .phase_i  ({PW{1'b0}}),
        .sample_o (modout_o)
    );

endmodule

// File: tb/tb_fsk_tx.sv
// Directed bench for fsk_tx: a fast-baud instance for framing/handshake and a
// BAUD_DIV=1000 instance for tone frequency and phase continuity.
module tb_fsk_tx;
    import fsk_pkg::*;

    localparam int DW       = 12;
    localparam int PW       = 24;
    localparam int NBITS    = 8;
    localparam int BD_A     = 16;
    localparam int BD_B     = 1000;
    localparam int L_DDS    = 3;
    localparam int MARK     = 3355443;
    localparam int SPACE    = 2516582;
    localparam int STEP_MAX = 2574;

    // Frame line patterns, index 0 = start bit, index 9 = stop bit.
    localparam logic [9:0] PAT_A5 = 10'b1101001010;
    localparam logic [9:0] PAT_00 = 10'b1000000000;
    localparam logic [9:0] PAT_FF = 10'b1111111110;
    localparam logic [9:0] PAT_3C = 10'b1001111000;
    localparam logic [9:0] PAT_81 = 10'b1100000010;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en_a = 1'b1;
    logic                 en_b = 1'b1;
    logic signed [PW-1:0] mark_a, space_a, mark_b, space_b;
    logic                 busy_a, tx_a, busy_b, tx_b;
    logic signed [PW-1:0] fw_a, fw_b;
    logic signed [DW-1:0] mod_a, mod_b;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    fsk_if #(.NBITS(NBITS)) if_a ();
    fsk_if #(.NBITS(NBITS)) if_b ();

    always #5 clk = ~clk;

    fsk_tx #(.DW(DW), .PW(PW), .NBITS(NBITS), .BAUD_DIV(BD_A)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_a),
        .mark_freq_i  (mark_a),
        .space_freq_i (space_a),
        .s_if         (if_a),
        .busy_o       (busy_a),
        .tx_bit_o     (tx_a),
        .freq_word_o  (fw_a),
        .modout_o     (mod_a)
    );

    fsk_tx #(.DW(DW), .PW(PW), .NBITS(NBITS), .BAUD_DIV(BD_B)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_b),
        .mark_freq_i  (mark_b),
        .space_freq_i (space_b),
        .s_if         (if_b),
        .busy_o       (busy_b),
        .tx_bit_o     (tx_b),
        .freq_word_o  (fw_b),
        .modout_o     (mod_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        n_total++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Call right after the accepting edge; checks every line cycle of the frame.
    task automatic check_frame_a(input string tag, input logic [9:0] pat);
        for (int c = 0; c < 10 * BD_A; c++) begin
            chk(tag, tx_a, pat[c / BD_A]);
            step();
        end
    endtask

    task automatic wait_ready_a(input string tag);
        for (int i = 0; i < 400 && !if_a.s_ready; i++) step();
        chk(tag, if_a.s_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int                   run;
        int                   rel;
        int                   w;
        int                   d;
        int                   zc [10];
        logic signed [DW-1:0] prev_s;

        mark_a = PW'(MARK);
        space_a = PW'(SPACE);
        mark_b = PW'(MARK);
        space_b = PW'(SPACE);
        if_a.s_data = '0;
        if_a.s_valid = 1'b0;
        if_b.s_data = '0;
        if_b.s_valid = 1'b0;

        // Reset held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rst s_ready", if_a.s_ready, 0);
            chk("rst busy", busy_a, 0);
            chk("rst tx_bit", tx_a, 1);
            chk("rst modout", mod_a, 0);
        end
        chk("rst freq word", fw_a, 0);
        rst = 1'b0;
        step();
        chk("post-rst s_ready", if_a.s_ready, 1);
        chk("post-rst freq word", fw_a, MARK);
        chk("post-rst freq word b", fw_b, MARK);

        // Single byte 0xA5
        if_a.s_data = 8'hA5;
        if_a.s_valid = 1'b1;
        step();
        if_a.s_valid = 1'b0;
        for (int c = 0; c < 10 * BD_A; c++) begin
            chk("A5 tx_bit", tx_a, PAT_A5[c / BD_A]);
            chk("A5 busy", busy_a, 1);
            chk("A5 s_ready", if_a.s_ready, 0);
            chk("A5 freq word", fw_a, PAT_A5[c / BD_A] ? MARK : SPACE);
            step();
        end
        chk("A5 s_ready at T+161", if_a.s_ready, 1);
        chk("A5 busy end", busy_a, 0);
        chk("A5 idle tx_bit", tx_a, 1);

        // Back-to-back 0x00 then 0xFF with s_valid held
        if_a.s_data = 8'h00;
        if_a.s_valid = 1'b1;
        step();
        if_a.s_data = 8'hFF;
        run = 0;
        for (int c = 0; c < 10 * BD_A; c++) begin
            chk("b2b 00 tx_bit", tx_a, PAT_00[c / BD_A]);
            run = tx_a ? run + 1 : 0;
            step();
        end
        chk("b2b ready", if_a.s_ready, 1);
        chk("b2b gap tx_bit", tx_a, 1);
        run = tx_a ? run + 1 : 0;
        step();
        if_a.s_valid = 1'b0;
        chk("b2b second accept", busy_a, 1);
        chk("b2b mark run", run, BD_A + 1);
        check_frame_a("b2b FF tx_bit", PAT_FF);
        chk("b2b idle after", busy_a, 0);

        // en toggled every cycle during a 0x3C frame
        en_a = 1'b0;
        #1;
        chk("en low s_ready", if_a.s_ready, 0);
        en_a = 1'b1;
        if_a.s_data = 8'h3C;
        if_a.s_valid = 1'b1;
        #1;
        chk("en high s_ready", if_a.s_ready, 1);
        step();
        if_a.s_valid = 1'b0;
        for (int c = 0; c < 20 * BD_A; c++) begin
            chk("gated 3C tx_bit", tx_a, PAT_3C[c / (2 * BD_A)]);
            en_a = ~en_a;
            step();
        end
        chk("gated end en", en_a, 1);
        chk("gated end busy", busy_a, 0);

        // Reset during data bit 3 of a 0x5A frame
        wait_ready_a("pre-abort ready");
        if_a.s_data = 8'h5A;
        if_a.s_valid = 1'b1;
        step();
        if_a.s_valid = 1'b0;
        rel = 1;
        while (rel < bit_start_cycle(3, BD_A) + 5) begin
            step();
            rel++;
        end
        chk("abort in bit3 tx_bit", tx_a, 1);
        chk("abort in bit3 busy", busy_a, 1);
        rst = 1'b1;
        step();
        chk("abort busy", busy_a, 0);
        chk("abort tx_bit", tx_a, 1);
        chk("abort s_ready", if_a.s_ready, 0);
        rst = 1'b0;
        step();
        chk("abort no resume", busy_a, 0);
        wait_ready_a("post-abort ready");

        // 0x81 frame with frame inputs disturbed mid-frame
        if_a.s_data = 8'h81;
        if_a.s_valid = 1'b1;
        step();
        if_a.s_valid = 1'b0;
        if_a.s_data = 8'hFF;
        mark_a = PW'(123);
        for (int c = 0; c < 10 * BD_A; c++) begin
            chk("81 tx_bit", tx_a, PAT_81[c / BD_A]);
            chk("81 freq word", fw_a, PAT_81[c / BD_A] ? MARK : SPACE);
            step();
        end
        chk("81 idle live mark", fw_a, 123);
        mark_a = PW'(MARK);

        // Tone frequency and phase continuity at BAUD_DIV = 1000
        for (int b = 0; b < 10; b++) zc[b] = 0;
        if_b.s_data = 8'hA5;
        if_b.s_valid = 1'b1;
        prev_s = mod_b;
        step();
        if_b.s_valid = 1'b0;
        for (int r = 1; r < 1 + 10 * BD_B + L_DDS; r++) begin
            if (r >= 1 + L_DDS) begin
                w = (r - 1 - L_DDS) / BD_B;
                if (mod_b[DW-1] != prev_s[DW-1]) zc[w]++;
                if ((r - 1 - L_DDS) % BD_B == 0) begin
                    d = int'(mod_b) - int'(prev_s);
                    chk_range("boundary step", d, -STEP_MAX, STEP_MAX);
                end
            end
            prev_s = mod_b;
            step();
        end
        for (int b = 0; b < 10; b++) begin
            chk_range(PAT_A5[b] ? "mark zero crossings" : "space zero crossings",
                      zc[b], (PAT_A5[b] ? 400 : 300) - 2, (PAT_A5[b] ? 400 : 300) + 2);
        end
        chk("b frame done busy", busy_b, 0);
        chk("b frame done tx_bit", tx_b, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
